// File: rtl/hybrid_adder8_pkg.sv
// hybrid_adder8_pkg
// Purpose: shared constants for the hybrid 8-bit adder slice.
// Contents: WIDTH, the fixed datapath width of the adder.
package hybrid_adder8_pkg;

  localparam int WIDTH = 8;

endpackage : hybrid_adder8_pkg

// File: rtl/hybrid_adder8_cla4.sv
// cla4
// Purpose: 4-bit carry-lookahead group covering bits 5:2 of the hybrid adder.
//          Every internal carry and the group carry-out are two-level
//          sum-of-products of the local generate/propagate terms and c2, so
//          the carry delay through this group does not grow with position.
// Ports:
//   X, Y   - addend bits 5:2 (local index 0 corresponds to adder bit 2)
//   c2     - carry into bit 2
//   S      - sum bits 5:2
//   c6     - carry out of bit 5
module cla4 (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       c2,
  output logic [3:0] S,
  output logic       c6
);

  wire [3:0] w_g;
  wire [3:0] w_p;
  wire [3:0] w_s;
  // w_c[k] is the carry into local bit k (adder bit k+2)
  wire [3:0] w_c;
  wire       w_c6;

  assign w_c[0] = c2;

  // Per-bit generate, propagate and sum
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      and u_g (w_g[gi], X[gi], Y[gi]);
      xor u_p (w_p[gi], X[gi], Y[gi]);
      xor u_s (w_s[gi], w_p[gi], w_c[gi]);
    end
  endgenerate

  // c3 = g2 | p2.c2
  wire w_c3_t0;
  and u_c3_a0 (w_c3_t0, w_p[0], c2);
  or  u_c3_o  (w_c[1], w_g[0], w_c3_t0);

  // c4 = g3 | p3.g2 | p3.p2.c2
  wire w_c4_t0, w_c4_t1;
  and u_c4_a0 (w_c4_t0, w_p[1], w_g[0]);
  and u_c4_a1 (w_c4_t1, w_p[1], w_p[0], c2);
  or  u_c4_o  (w_c[2], w_g[1], w_c4_t0, w_c4_t1);

  // c5 = g4 | p4.g3 | p4.p3.g2 | p4.p3.p2.c2
  wire w_c5_t0, w_c5_t1, w_c5_t2;
  and u_c5_a0 (w_c5_t0, w_p[2], w_g[1]);
  and u_c5_a1 (w_c5_t1, w_p[2], w_p[1], w_g[0]);
  and u_c5_a2 (w_c5_t2, w_p[2], w_p[1], w_p[0], c2);
  or  u_c5_o  (w_c[3], w_g[2], w_c5_t0, w_c5_t1, w_c5_t2);

  // c6 = g5 | p5.g4 | p5.p4.g3 | p5.p4.p3.g2 | p5.p4.p3.p2.c2
  wire w_c6_t0, w_c6_t1, w_c6_t2, w_c6_t3;
  and u_c6_a0 (w_c6_t0, w_p[3], w_g[2]);
  and u_c6_a1 (w_c6_t1, w_p[3], w_p[2], w_g[1]);
  and u_c6_a2 (w_c6_t2, w_p[3], w_p[2], w_p[1], w_g[0]);
  and u_c6_a3 (w_c6_t3, w_p[3], w_p[2], w_p[1], w_p[0], c2);
  or  u_c6_o  (w_c6, w_g[3], w_c6_t0, w_c6_t1, w_c6_t2, w_c6_t3);

  assign S  = w_s;
  assign c6 = w_c6;

endmodule : cla4

// File: rtl/hybrid_adder8_full_adder.sv
// full_adder
// Purpose: one-bit gate-level full adder used for the ripple segments.
// Ports:
//   a, b   - addend bits
//   cin    - carry in
//   s      - sum bit, a ^ b ^ cin
//   cout   - carry out, a&b | (a^b)&cin
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  wire w_p;
  wire w_g;
  wire w_pc;
  wire w_s;
  wire w_cout;

  xor u_xor_p  (w_p, a, b);
  xor u_xor_s  (w_s, w_p, cin);
  and u_and_g  (w_g, a, b);
  and u_and_pc (w_pc, w_p, cin);
  or  u_or_c   (w_cout, w_g, w_pc);

  assign s    = w_s;
  assign cout = w_cout;

endmodule : full_adder

// File: rtl/hybrid_adder8.sv
// hybrid_adder8
// Purpose: 8-bit adder with a ripple / lookahead / ripple carry chain
//          (bits 1:0 ripple, 5:2 lookahead, 7:6 ripple) plus a registered
//          copy of the result for pipelined consumers.
// Ports (positional order is fixed; legacy users pass only the first five):
//   S     - combinational sum X+Y+C0, bits 7:0
//   C8    - combinational carry out of bit 7
//   X, Y  - addends
//   C0    - carry into bit 0
//   clk   - clock for the output register only
//   rst   - synchronous active-high reset, clears S_r/C8_r only
//   S_r   - S captured at the last rising clk edge
//   C8_r  - C8 captured at the last rising clk edge
module hybrid_adder8
  import hybrid_adder8_pkg::*;
(
  output logic [WIDTH-1:0] S,
  output logic             C8,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C0,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] S_r,
  output logic             C8_r
);

  wire [WIDTH-1:0] w_sum;
  wire             w_c1;
  wire             w_c2;
  wire             w_c6;
  wire             w_c7;
  wire             w_c8;

  logic [WIDTH-1:0] r_sum;
  logic             r_c8;

  // Low ripple segment: bits 1:0
  full_adder u_fa0 (.a(X[0]), .b(Y[0]), .cin(C0),   .s(w_sum[0]), .cout(w_c1));
  full_adder u_fa1 (.a(X[1]), .b(Y[1]), .cin(w_c1), .s(w_sum[1]), .cout(w_c2));

  // Lookahead segment: bits 5:2
  cla4 u_cla (
    .X  (X[5:2]),
    .Y  (Y[5:2]),
    .c2 (w_c2),
    .S  (w_sum[5:2]),
    .c6 (w_c6)
  );

  // High ripple segment: bits 7:6
  full_adder u_fa6 (.a(X[6]), .b(Y[6]), .cin(w_c6), .s(w_sum[6]), .cout(w_c7));
  full_adder u_fa7 (.a(X[7]), .b(Y[7]), .cin(w_c7), .s(w_sum[7]), .cout(w_c8));

  assign S  = w_sum;
  assign C8 = w_c8;

  // Output register: capture the combinational result, reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= {WIDTH{1'b0}};
      r_c8  <= 1'b0;
    end else begin
      r_sum <= w_sum;
      r_c8  <= w_c8;
    end
  end

  assign S_r  = r_sum;
  assign C8_r = r_c8;

endmodule : hybrid_adder8

// File: tb/tb_hybrid_adder8.sv
// tb_hybrid_adder8
// Self-checking bench for hybrid_adder8: directed vectors, exhaustive sweep of
// the combinational adder, and randomized register-stage checks against a
// 9-bit arithmetic reference.
module tb_hybrid_adder8;

  logic [7:0] X;
  logic [7:0] Y;
  logic       C0;
  logic       clk;
  logic       rst;
  logic [7:0] S;
  logic       C8;
  logic [7:0] S_r;
  logic       C8_r;

  int n_cmp;
  int n_bad;

  hybrid_adder8 dut (
    .S    (S),
    .C8   (C8),
    .X    (X),
    .Y    (Y),
    .C0   (C0),
    .clk  (clk),
    .rst  (rst),
    .S_r  (S_r),
    .C8_r (C8_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned 9-bit sum
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic c);
    ref_sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  task automatic test_reset();
    logic [8:0] e;
    @(negedge clk);
    rst = 1'b1;
    X = 8'h5A; Y = 8'hC3; C0 = 1'b1;
    @(posedge clk); #1;
    e = ref_sum(X, Y, C0);
    n_cmp++;
    if ({C8_r, S_r} !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_reg: got C8_r=%b S_r=%h, need 0/00", C8_r, S_r);
    end
    n_cmp++;
    if ({C8, S} !== e) begin
      n_bad++;
      $display("FAIL reset_comb: got %h, need %h", {C8, S}, e);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] tx [7];
    logic [7:0] ty [7];
    logic       tc [7];
    logic [8:0] te [7];
    tx[0] = 8'b01100000; ty[0] = 8'b01111111; tc[0] = 1'b0; te[0] = {1'b0, 8'b11011111};
    tx[1] = 8'b11111111; ty[1] = 8'b11111110; tc[1] = 1'b0; te[1] = {1'b1, 8'b11111101};
    tx[2] = 8'b10101010; ty[2] = 8'b01010101; tc[2] = 1'b0; te[2] = {1'b0, 8'b11111111};
    tx[3] = 8'b00001000; ty[3] = 8'b10000001; tc[3] = 1'b0; te[3] = {1'b0, 8'b10001001};
    tx[4] = 8'b00001000; ty[4] = 8'b10000001; tc[4] = 1'b1; te[4] = {1'b0, 8'b10001010};
    tx[5] = 8'b00000001; ty[5] = 8'b00000000; tc[5] = 1'b1; te[5] = {1'b0, 8'b00000010};
    tx[6] = 8'b11110000; ty[6] = 8'b10001000; tc[6] = 1'b1; te[6] = {1'b1, 8'b01111001};
    for (int i = 0; i < 7; i++) begin
      X = tx[i]; Y = ty[i]; C0 = tc[i];
      #10;
      n_cmp++;
      if ({C8, S} !== te[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: got C8=%b S=%b, need C8=%b S=%b",
                 i, C8, S, te[i][8], te[i][7:0]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [16:0] v;
    logic [8:0]  e;
    int          shown;
    shown = 0;
    for (int k = 0; k < 131072; k++) begin
      v = k[16:0];
      X = v[7:0]; Y = v[15:8]; C0 = v[16];
      #1;
      e = ref_sum(X, Y, C0);
      n_cmp++;
      if ({C8, S} !== e) begin
        n_bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL sweep X=%h Y=%h C0=%b: got %h, need %h", X, Y, C0, {C8, S}, e);
        end
      end
    end
  endtask

  // Random inputs with optional random reset; registered outputs checked
  // after each edge and re-checked just before the next edge (hold).
  task automatic test_pipeline(input int cycles, input int rst_pct);
    logic [8:0] exp_reg;
    logic [8:0] e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      X = 8'($urandom); Y = 8'($urandom); C0 = 1'($urandom);
      rst = ($urandom_range(99) < rst_pct) ? 1'b1 : 1'b0;
      exp_reg = rst ? 9'h000 : ref_sum(X, Y, C0);
      @(posedge clk); #1;
      n_cmp++;
      if ({C8_r, S_r} !== exp_reg) begin
        n_bad++;
        $display("FAIL reg_capture cyc %0d rst=%b: got %h, need %h", i, rst, {C8_r, S_r}, exp_reg);
      end
      e = ref_sum(X, Y, C0);
      n_cmp++;
      if ({C8, S} !== e) begin
        n_bad++;
        $display("FAIL comb_during_reg cyc %0d rst=%b: got %h, need %h", i, rst, {C8, S}, e);
      end
      // Change inputs between edges; register must hold
      #2;
      X = ~X; Y = Y + 8'd1;
      #1;
      n_cmp++;
      if ({C8_r, S_r} !== exp_reg) begin
        n_bad++;
        $display("FAIL reg_hold cyc %0d: got %h, need %h", i, {C8_r, S_r}, exp_reg);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    X = 8'h00; Y = 8'h00; C0 = 1'b0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_pipeline(60, 0);
    test_pipeline(80, 30);
    test_reset();
    test_pipeline(20, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_hybrid_adder8
